vx_tensor_operand_packer: RTL and testbench

//  Transmit side of the tensor-core operand interface: gathers per-lane

---
 rtl/vx_tensor_operand_packer_pkg.sv | 37 +++
 rtl/vx_tensor_operand_packer_if.sv | 41 ++++
 rtl/vx_tensor_operand_packer_tile_slots.sv | 102 ++++++++++
 rtl/vx_tensor_operand_packer.sv | 140 ++++++++++++++
 tb/tb_vx_tensor_operand_packer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vx_tensor_operand_packer_pkg.sv
// Shared types for the tensor operand packer: beat tags, assembly states, tile layouts.
// Optional TENSOR_ZERO_ACC_EN build adds the zero-accumulator shortcut in the top level.
package VX_tensor_pkg;

    localparam int LANES    = 8;
    localparam int NW_WIDTH = 4;

    typedef enum logic [1:0] {
        BEAT_A  = 2'd0,
        BEAT_B  = 2'd1,
        BEAT_C0 = 2'd2,
        BEAT_C1 = 2'd3
    } beat_tag_e;

    typedef enum logic [1:0] {
        EXP_A  = 2'd0,
        EXP_B  = 2'd1,
        EXP_C0 = 2'd2,
        EXP_C1 = 2'd3
    } pack_state_e;

    typedef logic [LANES-1:0][31:0] lanes_t;
    typedef logic [3:0][1:0][31:0]  a_tile_t;
    typedef logic [1:0][3:0][31:0]  b_tile_t;
    typedef logic [3:0][3:0][31:0]  c_tile_t;
    typedef logic [1:0][3:0][31:0]  c_half_t;

    function automatic beat_tag_e expected_tag(input pack_state_e s);
        case (s)
            EXP_A:   return BEAT_A;
            EXP_B:   return BEAT_B;
            EXP_C0:  return BEAT_C0;
            default: return BEAT_C1;
        endcase
    endfunction

endpackage

// File: rtl/vx_tensor_operand_packer_if.sv
// Operand-beat input and tile output bundle between operand collection and the DPU.
// in_zero_c exists only when TENSOR_ZERO_ACC_EN is defined.
interface vx_tensor_operand_packer_if;
    import VX_tensor_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_beat;
    lanes_t              in_data;
    logic [NW_WIDTH-1:0] in_wid;
    logic                out_valid;
    logic                out_ready;
    a_tile_t             A_tile;
    b_tile_t             B_tile;
    c_tile_t             C_tile;
    logic [NW_WIDTH-1:0] out_wid;
    logic                err_seq;

`ifdef TENSOR_ZERO_ACC_EN
    logic                in_zero_c;

    modport master (
        output in_valid, in_beat, in_data, in_wid, in_zero_c, out_ready,
        input  in_ready, out_valid, A_tile, B_tile, C_tile, out_wid, err_seq
    );
    modport slave (
        input  in_valid, in_beat, in_data, in_wid, in_zero_c, out_ready,
        output in_ready, out_valid, A_tile, B_tile, C_tile, out_wid, err_seq
    );
`else
    modport master (
        output in_valid, in_beat, in_data, in_wid, out_ready,
        input  in_ready, out_valid, A_tile, B_tile, C_tile, out_wid, err_seq
    );
    modport slave (
        input  in_valid, in_beat, in_data, in_wid, out_ready,
        output in_ready, out_valid, A_tile, B_tile, C_tile, out_wid, err_seq
    );
`endif

endinterface

// File: rtl/vx_tensor_operand_packer_tile_slots.sv
// Ring of completed-tile slots; the tail slot doubles as the assembly buffer,
// filled field by field before push_i commits it.
module vx_tensor_tile_slots
    import VX_tensor_pkg::*;
#(
    parameter int NUM_SLOTS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we_a_i,
    input  logic                we_b_i,
    input  logic                we_c0_i,
    input  logic                we_c1_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  a_tile_t             a_i,
    input  b_tile_t             b_i,
    input  c_half_t             c_half_i,
    input  logic [NW_WIDTH-1:0] wid_i,
    output logic                full_o,
    output logic                valid_o,
    output a_tile_t             a_o,
    output b_tile_t             b_o,
    output c_tile_t             c_o,
    output logic [NW_WIDTH-1:0] wid_o
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    a_tile_t             a_q   [NUM_SLOTS];
    b_tile_t             b_q   [NUM_SLOTS];
    c_tile_t             c_q   [NUM_SLOTS];
    logic [NW_WIDTH-1:0] wid_q [NUM_SLOTS];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign full_o  = (count_q == CNT_W'(NUM_SLOTS));
    assign valid_o = (count_q != '0);
    assign a_o     = a_q[head_q];
    assign b_o     = b_q[head_q];
    assign c_o     = c_q[head_q];
    assign wid_o   = wid_q[head_q];

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = next_ptr(tail_q);
        end
        if (do_pop) begin
            head_d = next_ptr(head_q);
        end
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                c_q[s]   <= '0;
                wid_q[s] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (we_a_i) begin
                a_q[tail_q]   <= a_i;
                wid_q[tail_q] <= wid_i;
            end
            if (we_b_i) begin
                b_q[tail_q] <= b_i;
            end
            if (we_c0_i) begin
                c_q[tail_q][1:0] <= c_half_i;
            end
            if (we_c1_i) begin
                c_q[tail_q][3:2] <= c_half_i;
            end
        end
    end

endmodule

// File: rtl/vx_tensor_operand_packer.sv
// Tensor-core operand packer: sequences A/B/C0/C1 beats into tiles for the DPU.
// TENSOR_ZERO_ACC_EN enables the in_zero_c shortcut that completes a tile after B.
module vx_tensor_operand_packer
    import VX_tensor_pkg::*;
#(
    parameter int NUM_SLOTS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    vx_tensor_operand_packer_if.slave    bus
);

    pack_state_e         state_q, state_d;
    logic [NW_WIDTH-1:0] wid_q, wid_d;
    logic                err_q, err_d;
    logic                zero_c_q, zero_c_d;
    logic                zero_c_in;

    logic      accept, tag_err, wid_err, beat_err;
    logic      we_a, we_b, we_c0, we_c1, push;
    logic      full, valid;
    beat_tag_e beat;
    a_tile_t   a_scatter;
    b_tile_t   b_scatter;
    c_half_t   c_scatter;
    c_half_t   c_wdata;

`ifdef TENSOR_ZERO_ACC_EN
    assign zero_c_in = bus.in_zero_c;
`else
    assign zero_c_in = 1'b0;
`endif

    // Lane i sits at flat position row*cols+col in every tile, so each scatter is a packed reinterpretation.
    assign a_scatter = a_tile_t'(bus.in_data);
    assign b_scatter = b_tile_t'(bus.in_data);
    assign c_scatter = c_half_t'(bus.in_data);
    assign c_wdata   = (state_q == EXP_B) ? '0 : c_scatter;

    assign beat     = beat_tag_e'(bus.in_beat);
    assign accept   = bus.in_valid && bus.in_ready;
    assign tag_err  = (beat != expected_tag(state_q));
    assign wid_err  = (state_q != EXP_A) && (bus.in_wid != wid_q);
    assign beat_err = tag_err || wid_err;

    always_comb begin
        state_d  = state_q;
        wid_d    = wid_q;
        err_d    = 1'b0;
        zero_c_d = zero_c_q;
        we_a     = 1'b0;
        we_b     = 1'b0;
        we_c0    = 1'b0;
        we_c1    = 1'b0;
        push     = 1'b0;
        if (accept) begin
            if (beat_err) begin
                err_d   = 1'b1;
                state_d = EXP_A;
                if (beat == BEAT_A) begin
                    we_a     = 1'b1;
                    wid_d    = bus.in_wid;
                    zero_c_d = zero_c_in;
                    state_d  = EXP_B;
                end
            end else begin
                case (state_q)
                    EXP_A: begin
                        we_a     = 1'b1;
                        wid_d    = bus.in_wid;
                        zero_c_d = zero_c_in;
                        state_d  = EXP_B;
                    end
                    EXP_B: begin
                        we_b = 1'b1;
                        if (zero_c_q) begin
                            we_c0   = 1'b1;
                            we_c1   = 1'b1;
                            push    = 1'b1;
                            state_d = EXP_A;
                        end else begin
                            state_d = EXP_C0;
                        end
                    end
                    EXP_C0: begin
                        we_c0   = 1'b1;
                        state_d = EXP_C1;
                    end
                    default: begin
                        we_c1   = 1'b1;
                        push    = 1'b1;
                        state_d = EXP_A;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EXP_A;
            wid_q    <= '0;
            err_q    <= 1'b0;
            zero_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wid_q    <= wid_d;
            err_q    <= err_d;
            zero_c_q <= zero_c_d;
        end
    end

    vx_tensor_tile_slots #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slots (
        .clk      (clk),
        .reset    (reset),
        .we_a_i   (we_a),
        .we_b_i   (we_b),
        .we_c0_i  (we_c0),
        .we_c1_i  (we_c1),
        .push_i   (push),
        .pop_i    (bus.out_ready),
        .a_i      (a_scatter),
        .b_i      (b_scatter),
        .c_half_i (c_wdata),
        .wid_i    (bus.in_wid),
        .full_o   (full),
        .valid_o  (valid),
        .a_o      (bus.A_tile),
        .b_o      (bus.B_tile),
        .c_o      (bus.C_tile),
        .wid_o    (bus.out_wid)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = valid;
    assign bus.err_seq   = err_q;

endmodule

// File: tb/tb_vx_tensor_operand_packer.sv
// Directed bench for vx_tensor_operand_packer (NUM_SLOTS=2); the zero-accumulator
// case runs only when TENSOR_ZERO_ACC_EN is defined.
module tb_vx_tensor_operand_packer;
    import VX_tensor_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   failures;
    int   popCount;
    logic [NW_WIDTH-1:0] popWid[$];
    int   startPops;

    vx_tensor_operand_packer_if bus ();

    vx_tensor_operand_packer #(
        .NUM_SLOTS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake-completed tile so ordering and counts can be checked.
    always @(posedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            popCount++;
            popWid.push_back(bus.out_wid);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One beat: lane i carries base+i; waits (bounded) for in_ready, then holds for one edge.
    task automatic applyStimulus(input logic [1:0] tag, input logic [NW_WIDTH-1:0] wid,
                                 input int base, input logic zc);
        int budget;
        budget = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_beat  = tag;
        bus.in_wid   = wid;
        for (int i = 0; i < LANES; i++) begin
            bus.in_data[i] = 32'(base + i);
        end
`ifdef TENSOR_ZERO_ACC_EN
        bus.in_zero_c = zc;
`else
        if (zc) begin
            $display("[TB] note: in_zero_c ignored in this build");
        end
`endif
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            checkOutput("beat_accept_timeout", bus.in_ready, 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
`ifdef TENSOR_ZERO_ACC_EN
        bus.in_zero_c = 1'b0;
`endif
    endtask

    task automatic sendTile(input logic [NW_WIDTH-1:0] wid, input int base);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(2'(t), wid, base + 16 * t, 1'b0);
        end
    endtask

    initial begin
        tests     = 0;
        failures  = 0;
        popCount  = 0;
        reset     = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_beat   = 2'd0;
        bus.in_data   = '0;
        bus.in_wid    = '0;
        bus.out_ready = 1'b1;
`ifdef TENSOR_ZERO_ACC_EN
        bus.in_zero_c = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_err_seq", bus.err_seq, 0);
        checkOutput("reset_out_wid", bus.out_wid, 0);
        checkOutput("reset_a_zero", |bus.A_tile, 0);
        checkOutput("reset_c_zero", |bus.C_tile, 0);

        // Basic tile, wid=3, lane i = i + 16*tag.
        startPops = popCount;
        applyStimulus(2'd0, 4'd3, 0, 1'b0);
        checkOutput("t1_err_after_a", bus.err_seq, 0);
        applyStimulus(2'd1, 4'd3, 16, 1'b0);
        applyStimulus(2'd2, 4'd3, 32, 1'b0);
        checkOutput("t1_no_valid_before_c1", bus.out_valid, 0);
        applyStimulus(2'd3, 4'd3, 48, 1'b0);
        checkOutput("t1_out_valid", bus.out_valid, 1);
        checkOutput("t1_a10", bus.A_tile[1][0], 2);
        checkOutput("t1_b13", bus.B_tile[1][3], 23);
        checkOutput("t1_c12", bus.C_tile[1][2], 38);
        checkOutput("t1_c33", bus.C_tile[3][3], 55);
        checkOutput("t1_out_wid", bus.out_wid, 3);
        @(posedge clk);
        #1;
        checkOutput("t1_popped", bus.out_valid, 0);
        checkOutput("t1_pop_count", popCount - startPops, 1);

        // Backpressure: two tiles fill both slots.
        startPops = popCount;
        bus.out_ready = 1'b0;
        sendTile(4'd5, 0);
        checkOutput("t2_ready_one_slot", bus.in_ready, 1);
        checkOutput("t2_valid_one_slot", bus.out_valid, 1);
        sendTile(4'd6, 100);
        checkOutput("t2_ready_full", bus.in_ready, 0);
        checkOutput("t2_head_wid", bus.out_wid, 5);
        checkOutput("t2_head_a01", bus.A_tile[0][1], 1);
        @(negedge clk);
        checkOutput("t2_stable_wid", bus.out_wid, 5);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t2_ready_after_pop", bus.in_ready, 1);
        checkOutput("t2_second_wid", bus.out_wid, 6);
        checkOutput("t2_second_a01", bus.A_tile[0][1], 101);
        @(posedge clk);
        #1;
        checkOutput("t2_drained", bus.out_valid, 0);
        checkOutput("t2_pop_count", popCount - startPops, 2);
        checkOutput("t2_order_first", popWid[$-1], 5);
        checkOutput("t2_order_second", popWid[$], 6);

        // Wid mismatch on B discards the tile.
        startPops = popCount;
        applyStimulus(2'd0, 4'd1, 0, 1'b0);
        checkOutput("t3_err_after_a", bus.err_seq, 0);
        applyStimulus(2'd1, 4'd2, 16, 1'b0);
        checkOutput("t3_err_pulse", bus.err_seq, 1);
        checkOutput("t3_no_tile", bus.out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("t3_err_one_cycle", bus.err_seq, 0);
        sendTile(4'd1, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3_one_tile", popCount - startPops, 1);

        // A repeated A restarts assembly with the new A data.
        startPops = popCount;
        applyStimulus(2'd0, 4'd2, 0, 1'b0);
        applyStimulus(2'd1, 4'd2, 16, 1'b0);
        applyStimulus(2'd0, 4'd2, 200, 1'b0);
        checkOutput("t4_err_pulse", bus.err_seq, 1);
        applyStimulus(2'd1, 4'd2, 16, 1'b0);
        checkOutput("t4_no_err_on_b", bus.err_seq, 0);
        applyStimulus(2'd2, 4'd2, 32, 1'b0);
        applyStimulus(2'd3, 4'd2, 48, 1'b0);
        checkOutput("t4_valid", bus.out_valid, 1);
        checkOutput("t4_a01", bus.A_tile[0][1], 201);
        checkOutput("t4_a31", bus.A_tile[3][1], 207);
        checkOutput("t4_wid", bus.out_wid, 2);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_one_tile", popCount - startPops, 1);

        // Reset with a pending tile and a partial tile in flight.
        bus.out_ready = 1'b0;
        sendTile(4'd6, 0);
        applyStimulus(2'd0, 4'd7, 0, 1'b0);
        applyStimulus(2'd1, 4'd7, 16, 1'b0);
        applyStimulus(2'd2, 4'd7, 32, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("t5_valid_in_reset", bus.out_valid, 0);
        checkOutput("t5_ready_in_reset", bus.in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        startPops = popCount;
        applyStimulus(2'd0, 4'd5, 0, 1'b0);
        checkOutput("t5_clean_a_after_reset", bus.err_seq, 0);
        applyStimulus(2'd1, 4'd5, 16, 1'b0);
        applyStimulus(2'd2, 4'd5, 32, 1'b0);
        applyStimulus(2'd3, 4'd5, 48, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_one_tile", popCount - startPops, 1);
        checkOutput("t5_tile_wid", popWid[$], 5);

`ifdef TENSOR_ZERO_ACC_EN
        // Zero accumulator: tile completes on B with C cleared.
        startPops = popCount;
        applyStimulus(2'd0, 4'd4, 0, 1'b1);
        applyStimulus(2'd1, 4'd4, 16, 1'b0);
        checkOutput("t6_valid_after_b", bus.out_valid, 1);
        checkOutput("t6_c_zero", |bus.C_tile, 0);
        checkOutput("t6_b13", bus.B_tile[1][3], 23);
        checkOutput("t6_wid", bus.out_wid, 4);
        applyStimulus(2'd2, 4'd4, 32, 1'b0);
        checkOutput("t6_c0_err", bus.err_seq, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_one_tile", popCount - startPops, 1);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
